// File: rtl/hand_value_calc.sv
// ---------------------------------------------------------------------------
// hand_value_calc
//
// Purpose:
//   Blackjack hand scorer. On a start pulse it snapshots the player and
//   dealer card arrays. It then walks one slot per cycle, handling both hands
//   in parallel. At the end it applies the soft-ace rule and registers the
//   results. The outputs hold steady between passes and change only on the
//   cycle that done pulses.
//
// Ports:
//   clk                 system clock, posedge active
//   rst                 synchronous, active-high reset
//   start               one-cycle request to begin a pass (ignored while busy)
//   player_cards        player slot i at bits [CARD_W*i +: CARD_W]
//   dealer_cards        dealer slot i at bits [CARD_W*i +: CARD_W]
//   busy                high while a pass is in progress
//   done                one-cycle pulse, totals updated this cycle
//   total_player_value  player best total, saturated at 31
//   total_dealer_value  dealer best total, saturated at 31
//   player_soft         player total counts an ace as 11
//   dealer_soft         dealer total counts an ace as 11
//   player_card_cnt     non-empty player slots
//   dealer_card_cnt     non-empty dealer slots
//   player_blackjack    player has exactly two cards totalling 21
//
// Card codes: 0 = empty, 1 = ace, 2..10 = face value, 11..15 = 10.
// Start sampled at edge k gives done and new outputs after edge k+SLOTS+2.
// ---------------------------------------------------------------------------
module hand_value_calc #(
    parameter int SLOTS  = 9,
    parameter int CARD_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SLOTS*CARD_W-1:0]   player_cards,
    input  logic [SLOTS*CARD_W-1:0]   dealer_cards,
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                total_player_value,
    output logic [4:0]                total_dealer_value,
    output logic                      player_soft,
    output logic                      dealer_soft,
    output logic [3:0]                player_card_cnt,
    output logic [3:0]                dealer_card_cnt,
    output logic                      player_blackjack
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SNAP   = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_ADJUST = 2'd3;

    // Hand index 0 = player, 1 = dealer throughout.
    logic [1:0]                          state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [1:0][SLOTS-1:0][CARD_W-1:0]   snap_q, snap_d;
    logic [1:0][6:0]                     sum_q, sum_d;
    logic [1:0][3:0]                     aces_q, aces_d;
    logic [1:0][3:0]                     cnt_q, cnt_d;

    logic [1:0][CARD_W-1:0]              cur_c;
    logic [1:0][6:0]                     best_c;
    logic [1:0]                          soft_c;
    logic [1:0][4:0]                     sat_c;

    logic [1:0][4:0]                     tot_q;
    logic [1:0]                          soft_q;
    logic [1:0][3:0]                     ocnt_q;
    logic                                bj_q;
    logic                                done_q;

    // Face cards (11..15) score as 10. An empty slot (code 0) scores 0.
    function automatic logic [3:0] card_val(input logic [CARD_W-1:0] c);
        if (c > CARD_W'(10))
            card_val = 4'd10;
        else
            card_val = 4'(c);
    endfunction

    // Current slot and the soft-ace adjustment for each hand.
    // Only one ace is ever promoted, so the rule is raw + 10 <= 21.
    always_comb begin
        cur_c  = '0;
        best_c = '0;
        soft_c = '0;
        sat_c  = '0;
        for (int h = 0; h < 2; h++) begin
            cur_c[h]  = snap_q[h][idx_q];
            soft_c[h] = (aces_q[h] != 4'd0) && (sum_q[h] <= 7'd11);
            best_c[h] = soft_c[h] ? (sum_q[h] + 7'd10) : sum_q[h];
            sat_c[h]  = (best_c[h] > 7'd31) ? 5'd31 : best_c[h][4:0];
        end
    end

    // Walker next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        sum_d   = sum_q;
        aces_d  = aces_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_SNAP;
            end
            S_SNAP: begin
                snap_d[0] = player_cards;
                snap_d[1] = dealer_cards;
                sum_d     = '0;
                aces_d    = '0;
                cnt_d     = '0;
                idx_d     = '0;
                state_d   = S_ACCUM;
            end
            S_ACCUM: begin
                for (int h = 0; h < 2; h++) begin
                    sum_d[h] = sum_q[h] + 7'(card_val(cur_c[h]));
                    if (cur_c[h] != '0)
                        cnt_d[h] = cnt_q[h] + 4'd1;
                    if (cur_c[h] == CARD_W'(1))
                        aces_d[h] = aces_q[h] + 4'd1;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(SLOTS - 1))
                    state_d = S_ADJUST;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            sum_q   <= '0;
            aces_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            sum_q   <= sum_d;
            aces_q  <= aces_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers. They load only as the walker leaves ADJUST,
    // so nothing partial is ever visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q  <= '0;
            soft_q <= '0;
            ocnt_q <= '0;
            bj_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_ADJUST);
            if (state_q == S_ADJUST) begin
                tot_q  <= sat_c;
                soft_q <= soft_c;
                ocnt_q <= cnt_q;
                bj_q   <= (cnt_q[0] == 4'd2) && (best_c[0] == 7'd21);
            end
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign total_player_value = tot_q[0];
    assign total_dealer_value = tot_q[1];
    assign player_soft        = soft_q[0];
    assign dealer_soft        = soft_q[1];
    assign player_card_cnt    = ocnt_q[0];
    assign dealer_card_cnt    = ocnt_q[1];
    assign player_blackjack   = bj_q;

endmodule

// File: tb/tb_hand_value_calc.sv
// Self-checking bench for hand_value_calc. A card-rule reference model
// scores each hand directly from the slot codes.
module tb_hand_value_calc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [35:0] player_cards = '0;
    logic [35:0] dealer_cards = '0;
    logic        busy, done;
    logic [4:0]  total_player_value, total_dealer_value;
    logic        player_soft, dealer_soft;
    logic [3:0]  player_card_cnt, dealer_card_cnt;
    logic        player_blackjack;

    int n_checks = 0;
    int n_errors = 0;

    hand_value_calc #(.SLOTS(9), .CARD_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .player_cards(player_cards), .dealer_cards(dealer_cards),
        .busy(busy), .done(done),
        .total_player_value(total_player_value),
        .total_dealer_value(total_dealer_value),
        .player_soft(player_soft), .dealer_soft(dealer_soft),
        .player_card_cnt(player_card_cnt), .dealer_card_cnt(dealer_card_cnt),
        .player_blackjack(player_blackjack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference scoring. Returns {total(5), soft(1), count(4), blackjack(1)}.
    function automatic logic [10:0] score(input logic [35:0] cards);
        int s = 0, a = 0, n = 0, t;
        logic [3:0] c;
        logic sf;
        for (int i = 0; i < 9; i++) begin
            c = cards[i*4 +: 4];
            if (c != 0) n++;
            if (c == 1) a++;
            s += (c > 10) ? 10 : int'(c);
        end
        sf = (a > 0) && (s + 10 <= 21);
        t = sf ? s + 10 : s;
        return {5'(t > 31 ? 31 : t), sf, 4'(n), (n == 2 && t == 21)};
    endfunction

    function automatic logic [20:0] out_vec();
        return {total_player_value, player_soft, player_card_cnt, player_blackjack,
                total_dealer_value, dealer_soft, dealer_card_cnt};
    endfunction

    task automatic check_outputs(input string tag, input logic [35:0] pc, input logic [35:0] dc);
        logic [10:0] ep, ed;
        ep = score(pc);
        ed = score(dc);
        chk({tag, ".p_total"}, 32'(total_player_value), 32'(ep[10:6]));
        chk({tag, ".p_soft"},  32'(player_soft),        32'(ep[5]));
        chk({tag, ".p_cnt"},   32'(player_card_cnt),    32'(ep[4:1]));
        chk({tag, ".p_bj"},    32'(player_blackjack),   32'(ep[0]));
        chk({tag, ".d_total"}, 32'(total_dealer_value), 32'(ed[10:6]));
        chk({tag, ".d_soft"},  32'(dealer_soft),        32'(ed[5]));
        chk({tag, ".d_cnt"},   32'(dealer_card_cnt),    32'(ed[4:1]));
    endtask

    // Full pass: start, expect done 11 edges later, outputs steady until then.
    task automatic run_pass(input string tag, input logic [35:0] pc, input logic [35:0] dc);
        logic [20:0] prev;
        int cyc;
        logic changed, was_busy;
        player_cards = pc;
        dealer_cards = dc;
        prev = out_vec();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        changed = 1'b0;
        was_busy = busy;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (out_vec() !== prev) changed = 1'b1;
        end
        chk({tag, ".busy"}, 32'(was_busy), 32'd1);
        chk({tag, ".latency"}, 32'(cyc), 32'd11);
        chk({tag, ".hold"}, 32'(changed), 32'd0);
        check_outputs(tag, pc, dc);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [35:0] rand_hand();
        logic [35:0] h = '0;
        for (int i = 0; i < 9; i++)
            if ($urandom_range(0, 9) >= 3) h[i*4 +: 4] = 4'($urandom_range(1, 15));
        return h;
    endfunction

    initial begin
        logic [35:0] pa, da, pb, db;
        int ndone, dcyc;

        // 1: reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.outs", 32'(out_vec()), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (5) begin @(posedge clk); #1; if (done) ndone++; end
        chk("reset.no_done", 32'(ndone), 32'd0);

        // 2..4: directed hands
        run_pass("bj",    36'h0000000D1, 36'h000000005);
        run_pass("soft",  36'h000000911, 36'h111111111);
        run_pass("sat",   36'hAAAAAAAAA, 36'h00000070A);

        // 5: inputs changed mid-pass, start while busy and on the done edge
        pa = 36'h000000096; da = 36'h0000000B1;
        pb = 36'h0000000C1; db = 36'h000000342;
        player_cards = pa; dealer_cards = da;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = c;
                    check_outputs("midchg", pa, da);
                end
            end
            start = (c == 6) || (c == 10);
            if (c == 4) begin player_cards = pb; dealer_cards = db; end
        end
        chk("midchg.ndone", 32'(ndone), 32'd1);
        chk("midchg.latency", 32'(dcyc), 32'd11);
        run_pass("newin", pb, db);

        // 6: reset in the middle of a pass
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.outs", 32'(out_vec()), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (15) begin @(posedge clk); #1; if (done) ndone++; end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        run_pass("afterrst", 36'h000000A91, 36'h0000001A0);

        // Random hands
        for (int r = 0; r < 25; r++)
            run_pass($sformatf("rnd%0d", r), rand_hand(), rand_hand());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
